packet_channel_arbiter: RTL

Round-robin arbiter that shares a single registered `packet_t` channel (payload[7:0], valid, channel[1:0]) between up to four upstream requesters. It sits in front of the packet register stage. Each cycle it grants at most one requester, captures that requester's packet into a one-entry output register, and stamps the `channel` field with the granted requester index. An optional burst mode lets the winner keep the channel for several consecutive packets.

---
 rtl/packet_channel_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/packet_channel_arbiter.sv
// -----------------------------------------------------------------------------
// packet_channel_arbiter
//
// Round-robin arbiter that shares one registered packet_t channel between
// NUM_REQ (2..4) upstream requesters. Each cycle at most one requester is
// granted. Its packet is captured into a one-entry output register, and the
// channel field is overwritten with the granted index. With BURST_LEN > 1 the
// current winner may keep the channel for up to BURST_LEN consecutive packets.
//
// Optional feature macro: PKT_ARB_STATS_EN adds per-requester saturating
// 8-bit accept counters on grant_count.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   req_pkt      NUM_REQ requester packets (valid bit = request)
//   req_ready    one-hot/zero accept strobe, per requester
//   out_pkt      registered output packet (out_pkt.valid = output valid)
//   out_ready    downstream accepts out_pkt at this edge when valid
//   grant_id     index of the most recently accepted requester
//   dbg_state    output register state (EMPTY/FULL)
//   grant_count  (PKT_ARB_STATS_EN only) NUM_REQ x 8-bit accept counters
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream must hold req_pkt stable while valid and not ready.
// req_ready may depend combinationally on the valid bits. out_pkt is only
// consumed when out_pkt.valid and out_ready are both high.
// -----------------------------------------------------------------------------
package packet_channel_arbiter_pkg;
    typedef struct packed {
        logic [7:0] payload;
        logic       valid;
        logic [1:0] channel;
    } packet_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;
endpackage

module packet_channel_arbiter
    import packet_channel_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  packet_t [NUM_REQ-1:0] req_pkt,
    output logic [NUM_REQ-1:0]   req_ready,
    output packet_t              out_pkt,
    input  logic                 out_ready,
    output logic [1:0]           grant_id,
    output state_t               dbg_state
`ifdef PKT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*8-1:0] grant_count
`endif
);

    state_t     state_q, state_d;
    logic [7:0] payload_q, payload_d;
    logic [1:0] chan_q, chan_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;

    logic       load;
    logic       found;
    logic [1:0] winner;
    logic       owner_valid;
    logic       burst_hold;
    logic [7:0] win_payload;

    assign load = (state_q == ST_EMPTY) || out_ready;

    // Arbitration. burst_cnt_q == 0 means no grant has happened since reset,
    // so there is no burst owner yet and requester 0 gets first priority.
    always_comb begin
        owner_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(last_grant_q) && req_pkt[i].valid) begin
                owner_valid = 1'b1;
            end
        end
        burst_hold = (BURST_LEN > 1) && (burst_cnt_q != 4'd0) &&
                     (int'(burst_cnt_q) < BURST_LEN) && owner_valid;

        found  = 1'b0;
        winner = 2'd0;
        if (burst_hold) begin
            found  = 1'b1;
            winner = last_grant_q;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int idx;
                idx = (int'(last_grant_q) + k) % NUM_REQ;
                if (!found && req_pkt[idx].valid) begin
                    found  = 1'b1;
                    winner = idx[1:0];
                end
            end
        end

        win_payload = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(winner)) begin
                win_payload = req_pkt[i].payload;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && load && found) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == int'(winner)) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Next-state: accept a winner, drain to EMPTY, or hold while stalled.
    always_comb begin
        state_d      = state_q;
        payload_d    = payload_q;
        chan_d       = chan_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        burst_cnt_d  = burst_cnt_q;
        if (load && found) begin
            state_d      = ST_FULL;
            payload_d    = win_payload;
            chan_d       = winner;
            last_grant_d = winner;
            grant_id_d   = winner;
            if (winner == last_grant_q) begin
                // Saturate so a lone requester cannot wrap the count to 0.
                burst_cnt_d = (burst_cnt_q == 4'hF) ? burst_cnt_q : burst_cnt_q + 4'd1;
            end else begin
                burst_cnt_d = 4'd1;
            end
        end else if (load) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            payload_q    <= 8'd0;
            chan_q       <= 2'd0;
            last_grant_q <= 2'(NUM_REQ - 1);
            grant_id_q   <= 2'd0;
            burst_cnt_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            payload_q    <= payload_d;
            chan_q       <= chan_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    always_comb begin
        out_pkt.payload = payload_q;
        out_pkt.valid   = (state_q == ST_FULL);
        out_pkt.channel = chan_q;
    end

    assign grant_id  = grant_id_q;
    assign dbg_state = state_q;

`ifdef PKT_ARB_STATS_EN
    logic [7:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else if (load && found) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == int'(winner) && cnt_q[i] != 8'hFF) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count[i*8 +: 8] = cnt_q[i];
        end
    end
`endif

endmodule
